// File: rtl/pasta_pkg.sv
// Shared types and constants for the Pasta vector streamer.
package pasta_pkg;

  localparam int unsigned BITLEN  = 17;
  localparam int unsigned Q       = 65537;
  localparam int unsigned PASTA_S = 32;
  localparam int unsigned IDX_W   = 5;

  typedef logic [BITLEN-1:0]         coef_t;
  typedef logic [BITLEN*PASTA_S-1:0] pvec_t;
  typedef logic [IDX_W-1:0]          idx_t;

  typedef enum logic {StIdle, StStream} rd_state_e;

  // Element k sits in the k-th slice from the top; element 0 is the MSB slice.
  function automatic coef_t elem_sel(input pvec_t v, input idx_t k);
    int unsigned lsb;
    lsb = BITLEN * (PASTA_S - 1 - 32'(k));
    return v[lsb +: BITLEN];
  endfunction

endpackage

// File: rtl/pasta_vec_streamer_if.sv
// Load and coefficient-stream signals of the vector streamer.
interface pasta_vec_streamer_if;
  import pasta_pkg::*;

  pvec_t       vec_in;
  logic        vec_load;
  logic        vec_ready;
  coef_t       coef;
  logic        coef_valid;
  logic        coef_ready;
  idx_t        coef_idx;
  logic        coef_last;
  logic [15:0] vec_count;
  logic        err_range;
  logic        err_ovf;

  modport master (
    output vec_in, vec_load, coef_ready,
    input  vec_ready, coef, coef_valid, coef_idx, coef_last, vec_count, err_range, err_ovf
  );

  modport slave (
    input  vec_in, vec_load, coef_ready,
    output vec_ready, coef, coef_valid, coef_idx, coef_last, vec_count, err_range, err_ovf
  );

endinterface

// File: rtl/pasta_vec_slot.sv
// One ping-pong buffer slot: packed vector register, full bit, element select.
module pasta_vec_slot
  import pasta_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_load,
  input  logic  i_clear,
  input  pvec_t i_data,
  input  idx_t  i_idx,
  output logic  o_full,
  output coef_t o_elem
);

  pvec_t r_data;
  logic  r_full;

  // Capture the vector on load; drop the full bit once it has drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (i_load) begin
      r_data <= i_data;
      r_full <= 1'b1;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_elem = elem_sel(r_data, i_idx);

endmodule

// File: rtl/pasta_vec_streamer.sv
// Two-slot ping-pong buffer streaming packed coefficients one per cycle.
module pasta_vec_streamer
  import pasta_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  pasta_vec_streamer_if.slave  bus
);

  rd_state_e   r_state, w_state_d;
  idx_t        r_idx, w_idx_d;
  logic        r_wp, r_rp;
  logic [15:0] r_vec_count;
  logic        r_err_range, r_err_ovf;

  logic [1:0]  w_full, w_slot_load, w_slot_clear;
  coef_t       w_elem [2];
  logic        w_vec_ready, w_load, w_valid, w_xfer, w_final;
  coef_t       w_coef;

  // Registered full bits only, so no path from coef_ready/vec_load.
  assign w_vec_ready = ~(w_full[0] & w_full[1]);
  assign w_load      = bus.vec_load & w_vec_ready;
  assign w_valid     = (r_state == StStream);
  assign w_xfer      = w_valid & bus.coef_ready;
  assign w_final     = w_xfer & (r_idx == idx_t'(PASTA_S - 1));
  assign w_coef      = w_valid ? w_elem[r_rp] : '0;

  for (genvar g = 0; g < 2; g++) begin : g_slot
    assign w_slot_load[g]  = w_load & (r_wp == 1'(g));
    assign w_slot_clear[g] = w_final & (r_rp == 1'(g));

    pasta_vec_slot u_slot (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_slot_load[g]),
      .i_clear (w_slot_clear[g]),
      .i_data  (bus.vec_in),
      .i_idx   (r_idx),
      .o_full  (w_full[g]),
      .o_elem  (w_elem[g])
    );
  end

  // Read FSM next state and element index.
  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    unique case (r_state)
      // Both slots are empty here, so any accepted load lands in slot rp.
      StIdle: if (w_load) w_state_d = StStream;
      StStream: begin
        if (w_final) begin
          w_idx_d = '0;
          // A load in this cycle fills the other slot, keeping the stream gap-free.
          if (!(w_full[~r_rp] | w_load)) w_state_d = StIdle;
        end else if (w_xfer) begin
          w_idx_d = r_idx + 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State, pointers, counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_wp        <= 1'b0;
      r_rp        <= 1'b0;
      r_vec_count <= '0;
      r_err_range <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      if (w_load) r_wp <= ~r_wp;
      if (w_final) begin
        r_rp        <= ~r_rp;
        r_vec_count <= r_vec_count + 16'd1;
      end
      if (w_xfer && (w_coef >= coef_t'(Q))) r_err_range <= 1'b1;
      if (bus.vec_load && !w_vec_ready) r_err_ovf <= 1'b1;
    end
  end

  assign bus.vec_ready  = w_vec_ready;
  assign bus.coef       = w_coef;
  assign bus.coef_valid = w_valid;
  assign bus.coef_idx   = r_idx;
  assign bus.coef_last  = w_valid & (r_idx == idx_t'(PASTA_S - 1));
  assign bus.vec_count  = r_vec_count;
  assign bus.err_range  = r_err_range;
  assign bus.err_ovf    = r_err_ovf;

endmodule

// File: tb/tb_pasta_vec_streamer.sv
// Self-checking bench for pasta_vec_streamer against a coefficient-queue model.
module tb_pasta_vec_streamer;
  import pasta_pkg::*;

  typedef int unsigned elems_t [32];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pasta_vec_streamer_if bus ();

  pasta_vec_streamer u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: every buffered coefficient in delivery order, plus counters and flags.
  int unsigned exp_q[$];
  int unsigned m_count;
  bit          m_err_range;
  bit          m_err_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Index within the head vector: how many of its 32 elements are already gone.
  function automatic int unsigned m_idx();
    return (exp_q.size() == 0) ? 0 : (32 - (exp_q.size() % 32)) % 32;
  endfunction

  // Vectors still occupying storage (partially drained ones included).
  function automatic int unsigned m_held();
    return (exp_q.size() + 31) / 32;
  endfunction

  function automatic pvec_t pack(input elems_t e);
    pvec_t v;
    v = '0;
    for (int k = 0; k < 32; k++) v[BITLEN*(31-k) +: BITLEN] = e[k][BITLEN-1:0];
    return v;
  endfunction

  function automatic elems_t rand_vec(input int unsigned maxv);
    elems_t e;
    for (int k = 0; k < 32; k++) e[k] = $urandom_range(0, maxv);
    return e;
  endfunction

  task automatic check_outputs();
    bit v;
    v = (exp_q.size() != 0);
    check("coef_valid", bus.coef_valid, v);
    check("coef", bus.coef, v ? exp_q[0] : 0);
    check("coef_idx", bus.coef_idx, m_idx());
    check("coef_last", bus.coef_last, v && (m_idx() == 31));
    check("vec_ready", bus.vec_ready, m_held() < 2);
    check("vec_count", bus.vec_count, m_count % 65536);
    check("err_range", bus.err_range, m_err_range);
    check("err_ovf", bus.err_ovf, m_err_ovf);
  endtask

  // One cycle: check outputs, drive inputs, advance the model, clock.
  task automatic step(input bit load, input elems_t e, input bit rdy);
    int unsigned held;
    check_outputs();
    held = m_held();
    bus.vec_load   = load;
    bus.vec_in     = pack(e);
    bus.coef_ready = rdy;
    if (rdy && exp_q.size() != 0) begin
      int unsigned c;
      bit last;
      last = (m_idx() == 31);
      c = exp_q.pop_front();
      if (c >= Q) m_err_range = 1'b1;
      if (last) m_count++;
    end
    if (load) begin
      if (held < 2) for (int k = 0; k < 32; k++) exp_q.push_back(e[k]);
      else m_err_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.vec_load = 1'b0;
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_count     = 0;
    m_err_range = 1'b0;
    m_err_ovf   = 1'b0;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.vec_load   = 1'b0;
    bus.coef_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    check_outputs();
  endtask

  task automatic drain(input int unsigned pct_ready, input int bound);
    elems_t z;
    int n;
    z = rand_vec(0);
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      step(1'b0, z, $urandom_range(0, 99) < pct_ready);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    check_outputs();
  endtask

  task automatic advance_to_idx(input int unsigned target);
    elems_t z;
    int n;
    z = rand_vec(0);
    n = 0;
    while (m_idx() != target && n < 64) begin
      step(1'b0, z, 1'b1);
      n++;
    end
    check("advance_timeout", m_idx(), target);
  endtask

  initial begin
    elems_t e, a, b, c;
    int     loaded, n;
    bit     ld;

    rst            = 1'b1;
    bus.vec_in     = '0;
    bus.vec_load   = 1'b0;
    bus.coef_ready = 1'b0;
    model_clear();

    // Reset values.
    do_reset();

    // Single vector, ready held high: 1..32 on consecutive cycles.
    for (int k = 0; k < 32; k++) e[k] = k + 1;
    step(1'b1, e, 1'b1);
    check("t1_first_coef", bus.coef, 1);
    drain(100, 40);
    check("t1_vec_count", bus.vec_count, 1);

    // Overlapped vectors A and B, plus a rejected third load.
    do_reset();
    for (int k = 0; k < 32; k++) begin
      a[k] = 100 + k;
      b[k] = 200 + k;
    end
    c = rand_vec(65535);
    step(1'b1, a, 1'b1);
    step(1'b1, b, 1'b1);
    check("t2_vec_ready_low", bus.vec_ready, 0);
    step(1'b1, c, 1'b1);
    check("t2_err_ovf", bus.err_ovf, 1);
    drain(100, 80);
    check("t2_vec_count", bus.vec_count, 2);

    // Random back-pressure with random loads.
    do_reset();
    loaded = 0;
    n = 0;
    while ((loaded < 4 || exp_q.size() != 0) && n < 2000) begin
      ld = (loaded < 4) && (m_held() < 2) && ($urandom_range(0, 1) == 1);
      step(ld, rand_vec(65535), $urandom_range(0, 1) == 1);
      if (ld) loaded++;
      n++;
    end
    check("t3_timeout", exp_q.size(), 0);
    check("t3_vec_count", bus.vec_count, 4);

    // Range boundary: 65536 legal, 65537 illegal.
    do_reset();
    e = rand_vec(65535);
    e[0] = 65536;
    e[5] = 65537;
    step(1'b1, e, 1'b1);
    step(1'b0, e, 1'b1);
    check("t4_err_range_after_e0", bus.err_range, 0);
    drain(100, 40);
    check("t4_err_range_sticky", bus.err_range, 1);

    // Reset mid-stream at idx 10.
    do_reset();
    step(1'b1, rand_vec(65535), 1'b1);
    advance_to_idx(10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    check_outputs();
    e = rand_vec(65535);
    step(1'b1, e, 1'b1);
    check("t5_restart_idx", bus.coef_idx, 0);
    check("t5_restart_coef", bus.coef, e[0]);
    drain(100, 40);

    // Load coinciding with the idx-31 transfer.
    do_reset();
    a = rand_vec(65535);
    b = rand_vec(65535);
    step(1'b1, a, 1'b1);
    advance_to_idx(31);
    step(1'b1, b, 1'b1);
    check("t6_next_coef", bus.coef, b[0]);
    check("t6_vec_count", bus.vec_count, 1);
    drain(100, 40);
    check("t6_vec_count_end", bus.vec_count, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
